// File: rtl/dec1_2_pkg.sv
// rtl/dec1_2_pkg.sv - shared width and decode helper for the decoder tree leaf cell
package dec1_2_pkg;

    localparam int DEC_W = 2;

    // Gates on en first so an unknown select only leaks through while enabled.
    function automatic logic [DEC_W-1:0] decode1_2(input logic en, input logic a);
        logic [DEC_W-1:0] d;
        d[0] = en & ~a;
        d[1] = en &  a;
        return d;
    endfunction

endpackage

// File: rtl/dec1_2.sv
// rtl/dec1_2.sv - 1-to-2 line decoder with enable, combinational plus registered output
module dec1_2
    import dec1_2_pkg::*;
#(
    parameter logic [DEC_W-1:0] RESET_VAL = 2'b00
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             a,
    input  logic             en,
    output logic [DEC_W-1:0] out,
    output logic [DEC_W-1:0] out_q
);

    logic [DEC_W-1:0] out_d;

    always_comb begin
        out_d = decode1_2(en, a);
        out   = out_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_q <= RESET_VAL;
        end else begin
            out_q <= out_d;
        end
    end

endmodule

// File: tb/tb_dec1_2.sv
// tb/tb_dec1_2.sv - directed self-checking bench for dec1_2
module tb_dec1_2;

    logic       clk;
    logic       reset_n;
    logic       a;
    logic       en;
    logic [1:0] out;
    logic [1:0] out_q;

    int n_checks;
    int n_fail;

    dec1_2 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .a       (a),
        .en      (en),
        .out     (out),
        .out_q   (out_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(out or a or en) begin
        #0;
        if (!$isunknown({a, en})) begin
            assert ($onehot0(out))
                else $error("onehot0 violated out=%b", out);
        end
    end

    task automatic check_eq(input string tag, input logic [1:0] got, input logic [1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    initial begin
        logic [1:0] prev;
        logic [2:0] a_seq;
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        en       = 1'b0;
        a        = 1'b0;

        // Disabled: output stays zero for either select value
        #3;
        check_eq("reset_out_q", out_q, 2'b00);
        check_eq("en0_a0", out, 2'b00);
        a = 1'b1;
        #10;
        check_eq("en0_a1", out, 2'b00);

        // Enabled: zero latency, no clock edge involved
        @(posedge clk);
        #2;
        en = 1'b1;
        a  = 1'b0;
        #1;
        check_eq("en1_a0", out, 2'b01);
        a = 1'b1;
        #1;
        check_eq("en1_a1", out, 2'b10);

        // Reset held with clock running, then first capture
        @(posedge clk);
        #1;
        check_eq("rst_hold_out_q", out_q, 2'b00);
        check_eq("rst_hold_out", out, 2'b10);
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check_eq("rst_release_no_edge", out_q, 2'b00);
        @(posedge clk);
        #1;
        check_eq("first_capture", out_q, 2'b10);

        // Registered latency: out_q trails out by one cycle
        a_seq = 3'b010;
        prev  = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = a_seq[2-i];
            #1;
            check_eq("lat_out", out, a_seq[2-i] ? 2'b10 : 2'b01);
            check_eq("lat_out_q_before", out_q, prev);
            @(posedge clk);
            #1;
            prev = a_seq[2-i] ? 2'b10 : 2'b01;
            check_eq("lat_out_q_after", out_q, prev);
        end

        // Asynchronous reset between edges while out_q=01
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_eq("async_rst_out_q", out_q, 2'b00);
        check_eq("async_rst_out", out, 2'b01);
        @(posedge clk);
        #1;
        check_eq("async_rst_held", out_q, 2'b00);
        @(negedge clk);
        reset_n = 1'b1;

        // Exhaustive {en,a} sweep
        for (int k = 0; k < 4; k++) begin
            logic [1:0] combo;
            logic [1:0] exp_out;
            combo = k[1:0];
            en = combo[1];
            a  = combo[0];
            exp_out = (combo == 2'b11) ? 2'b10 : (combo == 2'b10) ? 2'b01 : 2'b00;
            #1;
            check_eq("sweep_out", out, exp_out);
            check_eq("sweep_onehot0", {1'b0, $onehot0(out)}, 2'b01);
        end

        // Capture of the final sweep value
        @(posedge clk);
        #1;
        check_eq("sweep_capture", out_q, 2'b10);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
